// File: rtl/mul_div_pkg.sv
// ============================================================================
// mul_div_pkg : shared state encoding and opcode constants for mul_div_unit
// Rev 1.0
// ============================================================================
`default_nettype none

package mul_div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2,
    DZ     = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mul_div_sign_fix.sv
// ============================================================================
// mul_div_sign_fix : conditional two's-complement negate of a WIDTH-bit value
// Rev 1.0
// ============================================================================
`default_nettype none

module mul_div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] res_o
);

  assign res_o = neg_i ? ((~val_i) + WIDTH'(1)) : val_i;

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// mul_div_unit : iterative radix-2 multiply/divide producing HI/LO results
// Rev 1.0
// ============================================================================
`default_nettype none

module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  import mul_div_pkg::*;

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 op_q, op_d;
  logic                 neg_q, neg_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 div_zero_q, div_zero_d;

  logic                 w_neg_a;
  logic                 w_neg_b;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_div_shift;
  logic                 w_div_ge;
  logic [WIDTH-1:0]     w_div_sub;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;

  assign w_neg_a = is_signed & a[WIDTH-1];
  assign w_neg_b = is_signed & b[WIDTH-1];

  mul_div_sign_fix #(.WIDTH(WIDTH)) u_mag_a (
    .val_i (a),
    .neg_i (w_neg_a),
    .res_o (w_mag_a)
  );

  mul_div_sign_fix #(.WIDTH(WIDTH)) u_mag_b (
    .val_i (b),
    .neg_i (w_neg_b),
    .res_o (w_mag_b)
  );

  // Multiply: acc = {partial product, remaining multiplier bits}; the add
  // keeps its carry so the right shift never loses the top bit.
  assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits still to shift in /
  // quotient bits shifted in from the right}.
  assign w_div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, opb_q});
  assign w_div_sub   = WIDTH'(w_div_shift - {1'b0, opb_q});
  assign w_div_next  = {(w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], w_div_ge};

  mul_div_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .val_i (acc_q),
    .neg_i (neg_q),
    .res_o (w_prod)
  );

  mul_div_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
    .val_i (acc_q[WIDTH-1:0]),
    .neg_i (neg_q),
    .res_o (w_quo)
  );

  mul_div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .val_i (acc_q[2*WIDTH-1:WIDTH]),
    .neg_i (neg_rem_q),
    .res_o (w_rem)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MULT;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      opb_q      <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d       = op;
          opb_d      = w_mag_b;
          acc_d      = {{WIDTH{1'b0}}, w_mag_a};
          neg_d      = w_neg_a ^ w_neg_b;
          neg_rem_d  = w_neg_a;
          div_zero_d = 1'b0;
          cnt_d      = CNT_W'(WIDTH);
          if ((op == OP_DIV) && (b == '0)) begin
            state_d = DZ;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = (op_q == OP_DIV) ? w_div_next : w_mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        if (op_q == OP_DIV) begin
          hi_d = w_rem;
          lo_d = w_quo;
        end else begin
          hi_d = w_prod[2*WIDTH-1:WIDTH];
          lo_d = w_prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      DZ: begin
        done_d     = 1'b1;
        div_zero_d = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// tb_mul_div_unit : directed vector bench for mul_div_unit (WIDTH = 32)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;

  int errors = 0;
  int checks = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .div_zero  (div_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         op;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // done and busy must never be high together
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      checks++;
      if (busy === 1'b1 && done === 1'b1) begin
        errors++;
        $display("FAIL busy_done_overlap: got busy=1 done=1 expected not both high");
      end
    end
  end

  task automatic run_op(input logic o, input logic s, input logic [W-1:0] va,
                        input logic [W-1:0] vb, output int lat, output logic busy1);
    op = o; is_signed = s; a = va; b = vb; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat   = 1;
    busy1 = busy;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  initial begin
    int   lat;
    logic busy1;
    int   n;

    //         op sgn a             b             hi            lo            dz lat
    vecs[0]  = '{1'b0, 1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
    vecs[1]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, 34};
    vecs[2]  = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    vecs[3]  = '{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    vecs[4]  = '{1'b1, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34};
    vecs[5]  = '{1'b1, 1'b0, 32'd5,        32'd0,        32'd2,        32'd14,       1'b1, 2};
    vecs[6]  = '{1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
    vecs[7]  = '{1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
    vecs[8]  = '{1'b1, 1'b0, 32'd3,        32'd10,       32'd3,        32'd0,        1'b0, 34};
    vecs[9]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34};
    vecs[10] = '{1'b1, 1'b1, 32'hFFFFFFF8, 32'd0,        32'h00000000, 32'h00000001, 1'b1, 2};
    vecs[11] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, 34};
    vecs[12] = '{1'b0, 1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 34};
    vecs[13] = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, 34};

    reset = 1'b1; start = 1'b0; op = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_hi",   64'(hi),   64'(0));
    check("reset_lo",   64'(lo),   64'(0));
    check("reset_dz",   64'(div_zero), 64'(0));

    // Each new start lands in the done cycle of the previous operation.
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, lat, busy1);
      check($sformatf("v%0d_lat", i),   64'(lat),      64'(vecs[i].lat));
      check($sformatf("v%0d_busy", i),  64'(busy1),    64'(1));
      check($sformatf("v%0d_hi", i),    64'(hi),       64'(vecs[i].hi));
      check($sformatf("v%0d_lo", i),    64'(lo),       64'(vecs[i].lo));
      check($sformatf("v%0d_dz", i),    64'(div_zero), 64'(vecs[i].dz));
    end

    // Start pulsed mid-run with other operands must be ignored.
    op = 1'b0; is_signed = 1'b1; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 100) begin
      if (n == 5) begin
        op = 1'b1; is_signed = 1'b0; a = 32'd100; b = 32'd100; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0;
    check("ign_lat", 64'(n),  64'(34));
    check("ign_hi",  64'(hi), 64'(0));
    check("ign_lo",  64'(lo), 64'(42));
    @(posedge clock); #1;
    check("hold_done", 64'(done), 64'(0));
    check("hold_busy", 64'(busy), 64'(0));
    check("hold_lo",   64'(lo),   64'(42));

    // Reset in the middle of a run discards it.
    op = 1'b0; is_signed = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 1;
    while (n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    check("run10_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("mrst_busy", 64'(busy), 64'(0));
    check("mrst_done", 64'(done), 64'(0));
    check("mrst_hi",   64'(hi),   64'(0));
    check("mrst_lo",   64'(lo),   64'(0));

    run_op(1'b1, 1'b0, 32'd100, 32'd7, lat, busy1);
    check("fresh_lat", 64'(lat),      64'(34));
    check("fresh_hi",  64'(hi),       64'(2));
    check("fresh_lo",  64'(lo),       64'(14));
    check("fresh_dz",  64'(div_zero), 64'(0));

    @(posedge clock); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit that produces the HI/LO results for mult, multu, div and divu in the multicycle CPU.
- Sits between the A/B operand registers and the HI/LO register write muxes.
- Driven by the control unit through a start/busy/done handshake.
- Generalises operand width and adds an unsigned mode and an explicit divide-by-zero flag.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each; must be >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  1  0 = multiply, 1 = divide; sampled with start.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- a  in  WIDTH  multiplicand / dividend; sampled with start.
- b  in  WIDTH  multiplier / divisor; sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when the result is valid.
- hi  out  WIDTH  product upper half / remainder.
- lo  out  WIDTH  product lower half / quotient.
- div_zero  out  1  set with done when a divide had b == 0; cleared on next accepted start.

Behaviour:
- One clock (clock); reset is synchronous and active-high (reset).
- Reset (any state, including mid-operation): state = IDLE; busy, done, div_zero = 0; hi, lo = 0; counter = 0. Any in-flight operation is discarded.
- State machine: IDLE -> RUN -> FINISH -> IDLE.
- Zero-divisor path: IDLE -> DZ -> IDLE.
- IDLE:
  - busy = 0.
  - On start = 1: latch op, is_signed and the magnitudes of a and b. Magnitudes are taken only if is_signed = 1; otherwise the raw values are used.
  - Record the result signs.
  - Divide with b == 0: go to DZ.
  - Otherwise: load counter = WIDTH and go to RUN.
- RUN:
  - busy = 1.
  - Each cycle performs one radix-2 step:
    - Multiply: shift-add on a 2*WIDTH accumulator.
    - Divide: restoring shift-subtract on a WIDTH+1 partial remainder.
  - Counter decrements by 1; leave to FINISH when the counter reaches 0 after its decrement. That is exactly WIDTH RUN cycles.
- FINISH:
  - busy = 1.
  - Apply sign correction and write hi/lo.
  - Next cycle: done = 1, busy = 0, state IDLE.
- DZ:
  - busy = 1 for one cycle.
  - Next cycle: done = 1, div_zero = 1; hi/lo keep their previous values.
- Latency:
  - Normal operation: done is asserted WIDTH+2 cycles after the cycle in which start was sampled.
  - Divide by zero: done is asserted 2 cycles after start.
- hi/lo hold their value from the done cycle until the next done or reset. They never change while busy.
- Signed multiply: full 2*WIDTH two's-complement product; hi = upper WIDTH bits, lo = lower WIDTH bits.
- Unsigned multiply: same split, unsigned product.
- Signed divide:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Overflow case a = MIN, b = -1: lo = MIN, hi = 0 (wrap), no flag.
- Unsigned divide: standard unsigned quotient and remainder.
- start while busy = 1: ignored, no effect on the current operation.
- start in the same cycle that done is high: accepted, because state is IDLE in the done cycle.
- done and busy are never high together.
- div_zero is cleared when the next start is accepted. It is never set by a multiply.

Decomposition:
- Shared package mul_div_pkg holds:
  - state encoding (IDLE, RUN, FINISH, DZ, 2 bits);
  - op constants OP_MULT = 0, OP_DIV = 1.
- One sub-module, mul_div_sign_fix: combinational conditional two's-complement negate, used for operand magnitude and result sign correction. Parametrised by WIDTH.
- Everything else stays in mul_div_unit.

Test Plan:
- Signed multiply, WIDTH=32, a=0xFFFFFFFD (-3), b=7 -> done 34 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_zero=0.
- Unsigned multiply, a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE.
- Signed divide, a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Unsigned divide, a=100, b=7 -> lo=14, hi=2.
- Signed divide, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero after a previous result hi=2, lo=14, with a=5, b=0 -> done 2 cycles after start, div_zero=1, hi=2, lo=14.
- Handshake and reset checks (one bench pass):
  - Pulse start again at RUN cycle 5 with different operands -> ignored; original result is produced.
  - Assert reset at RUN cycle 10 -> next cycle busy=0, done=0, hi=lo=0.
  - A fresh start after that completes normally.
